fetch_top: RTL and testbench

//  Instruction fetch stage: owns the PC and reads instruction memory. Applies static branch prediction
//  (JAL always taken; backward B-type taken; forward B-type not taken). Drives registered IF/ID outputs

---
 rtl/fetch_top.sv | 89 ++++++++
 tb/tb_fetch_top.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_top.sv
// fetch_top: RV32I fetch stage owning the PC, with static branch prediction
// (JAL and backward branches taken) and registered IF/ID outputs.
module fetch_top #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic [31:0] i_imem_rdat,
    input  logic        i_imem_vld,
    input  logic        i_intrlock_bubble,
    input  logic        i_ex_branch_flush,
    input  logic [31:0] i_ex_branch_tgt,
    output logic [31:0] o_if_inst,
    output logic [31:0] o_if_pc,
    output logic        o_if_branch_taken,
    output logic [31:0] o_if_branch_nt_pc,
    output logic [31:0] o_if_jalr_pci
);
    localparam logic [0:0]  S_BOOT    = 1'b0;
    localparam logic [0:0]  S_RUN     = 1'b1;
    localparam logic [6:0]  OP_JAL    = 7'b1101111;
    localparam logic [6:0]  OP_BRANCH = 7'b1100011;
    localparam logic [31:0] BUBBLE    = 32'h0000_0013;

    logic [0:0]  r_state;
    logic [31:0] r_pc;
    logic [31:0] r_inst;
    logic [31:0] r_if_pc;
    logic        r_taken;
    logic [31:0] r_nt_pc;
    logic [31:0] r_jalr_pci;

    logic [31:0] w_i_imm;
    logic [31:0] w_b_imm;
    logic [31:0] w_j_imm;
    logic        w_jal;
    logic        w_bwd;
    logic [31:0] w_next;

    assign w_i_imm = {{20{i_imem_rdat[31]}}, i_imem_rdat[31:20]};
    assign w_b_imm = {{20{i_imem_rdat[31]}}, i_imem_rdat[7], i_imem_rdat[30:25], i_imem_rdat[11:8], 1'b0};
    assign w_j_imm = {{12{i_imem_rdat[31]}}, i_imem_rdat[19:12], i_imem_rdat[20], i_imem_rdat[30:21], 1'b0};
    assign w_jal   = i_imem_rdat[6:0] == OP_JAL;
    // a branch is backward exactly when its immediate's sign bit is set
    assign w_bwd   = i_imem_rdat[6:0] == OP_BRANCH && i_imem_rdat[31];
    assign w_next  = r_pc + (w_jal ? w_j_imm : w_bwd ? w_b_imm : 32'd4);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_BOOT;
            r_pc       <= RESET_PC;
            r_inst     <= BUBBLE;
            r_if_pc    <= '0;
            r_taken    <= 1'b0;
            r_nt_pc    <= '0;
            r_jalr_pci <= '0;
        end else if (r_state == S_BOOT) begin
            r_state <= S_RUN;
            r_inst  <= BUBBLE;
            r_taken <= 1'b0;
        end else if (i_ex_branch_flush) begin
            r_pc    <= i_ex_branch_tgt;
            r_inst  <= BUBBLE;
            r_taken <= 1'b0;
        end else if (!i_intrlock_bubble) begin
            if (i_imem_vld) begin
                r_inst     <= i_imem_rdat;
                r_if_pc    <= r_pc;
                r_taken    <= w_jal | w_bwd;
                r_nt_pc    <= r_pc + 32'd4;
                r_jalr_pci <= r_pc + w_i_imm;
                r_pc       <= w_next;
            end else begin
                r_inst  <= BUBBLE;
                r_taken <= 1'b0;
            end
        end
    end

    assign o_imem_req        = r_state == S_RUN;
    assign o_imem_addr       = r_pc;
    assign o_if_inst         = r_inst;
    assign o_if_pc           = r_if_pc;
    assign o_if_branch_taken = r_taken;
    assign o_if_branch_nt_pc = r_nt_pc;
    assign o_if_jalr_pci     = r_jalr_pci;
endmodule

// File: tb/tb_fetch_top.sv
// tb_fetch_top: directed vector table, hand-written corner sequences and a
// randomized run against a behavioural fetch model.
module tb_fetch_top;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdat;
    logic        imem_vld = 1'b1;
    logic        bubble = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] tgt = '0;
    logic [31:0] if_inst;
    logic [31:0] if_pc;
    logic        if_taken;
    logic [31:0] if_nt_pc;
    logic [31:0] if_jalr_pci;

    logic [31:0] mem [256];
    int n_chk = 0;
    int n_err = 0;

    fetch_top #(.RESET_PC(32'h0)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .o_imem_req(imem_req),
        .o_imem_addr(imem_addr),
        .i_imem_rdat(imem_rdat),
        .i_imem_vld(imem_vld),
        .i_intrlock_bubble(bubble),
        .i_ex_branch_flush(flush),
        .i_ex_branch_tgt(tgt),
        .o_if_inst(if_inst),
        .o_if_pc(if_pc),
        .o_if_branch_taken(if_taken),
        .o_if_branch_nt_pc(if_nt_pc),
        .o_if_jalr_pci(if_jalr_pci)
    );

    assign imem_rdat = mem[imem_addr[9:2]];
    always #5 clk = ~clk;

    function automatic logic [31:0] enc_j(input int imm);
        logic [31:0] v;
        v = imm;
        return {v[20], v[10:1], v[11], v[19:12], 5'd0, 7'h6F};
    endfunction

    function automatic logic [31:0] enc_b(input int imm);
        logic [31:0] v;
        v = imm;
        return {v[12], v[10:5], 5'd0, 5'd0, 3'd0, v[4:1], v[11], 7'h63};
    endfunction

    function automatic logic [31:0] enc_jalr(input int imm);
        logic [31:0] v;
        v = imm;
        return {v[11:0], 5'd0, 3'd0, 5'd1, 7'h67};
    endfunction

    function automatic int sx(input logic [31:0] v, input int bits);
        int t;
        t = v << (32 - bits);
        return t >>> (32 - bits);
    endfunction

    // behavioural model: state of the fetch stage in spec terms
    logic [31:0] m_pc, m_inst, m_pcq, m_nt, m_jalr;
    logic        m_taken, m_valid, m_run;

    task automatic m_reset();
        m_pc = 0; m_inst = NOP; m_pcq = 0; m_nt = 0; m_jalr = 0;
        m_taken = 0; m_valid = 1; m_run = 0;
    endtask

    task automatic m_step();
        logic [31:0] w;
        int off;
        logic t;
        w = mem[m_pc[9:2]];
        if (!m_run) begin
            m_run = 1; m_inst = NOP; m_taken = 0;
        end else if (flush) begin
            m_pc = tgt; m_inst = NOP; m_taken = 0; m_valid = 0;
        end else if (!bubble) begin
            if (!imem_vld) begin
                m_inst = NOP; m_taken = 0; m_valid = 0;
            end else begin
                off = 4; t = 0;
                if (w[6:0] == 7'h6F) begin
                    off = sx({11'd0, w[31], w[19:12], w[20], w[30:21], 1'b0}, 21); t = 1;
                end else if (w[6:0] == 7'h63 && sx({19'd0, w[31], w[7], w[30:25], w[11:8], 1'b0}, 13) < 0) begin
                    off = sx({19'd0, w[31], w[7], w[30:25], w[11:8], 1'b0}, 13); t = 1;
                end
                m_inst = w; m_pcq = m_pc; m_taken = t; m_nt = m_pc + 4;
                m_jalr = m_pc + sx({20'd0, w[31:20]}, 12);
                m_pc = m_pc + off; m_valid = 1;
            end
        end
    endtask

    task automatic step();
        m_step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        n_chk++;
        if (a !== e) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
        end
    endtask

    task automatic chk_reset();
        chk("rst_req", 32'(imem_req), 0);
        chk("rst_addr", imem_addr, 0);
        chk("rst_inst", if_inst, NOP);
        chk("rst_pc", if_pc, 0);
        chk("rst_taken", 32'(if_taken), 0);
        chk("rst_nt", if_nt_pc, 0);
        chk("rst_jalr", if_jalr_pci, 0);
    endtask

    typedef struct {
        logic        fl, bb, vl;
        logic [31:0] tg, addr, inst, pc;
        logic        tk;
        logic [31:0] nt;
    } vec_t;
    vec_t tv[9];

    initial begin
        foreach (mem[i]) mem[i] = NOP;
        mem[4]    = enc_j(256);
        mem[68]   = enc_j(-240);
        mem[8]    = enc_b(-8);
        tv[0] = '{0, 0, 1, 0, 32'h000, NOP, 32'h000, 0, 32'h000};
        tv[1] = '{0, 0, 1, 0, 32'h004, NOP, 32'h000, 0, 32'h004};
        tv[2] = '{0, 0, 1, 0, 32'h008, NOP, 32'h004, 0, 32'h008};
        tv[3] = '{0, 0, 1, 0, 32'h00C, NOP, 32'h008, 0, 32'h00C};
        tv[4] = '{0, 0, 1, 0, 32'h010, NOP, 32'h00C, 0, 32'h010};
        tv[5] = '{0, 0, 1, 0, 32'h110, enc_j(256), 32'h010, 1, 32'h014};
        tv[6] = '{0, 0, 1, 0, 32'h020, enc_j(-240), 32'h110, 1, 32'h114};
        tv[7] = '{0, 0, 1, 0, 32'h018, enc_b(-8), 32'h020, 1, 32'h024};
        tv[8] = '{0, 0, 1, 0, 32'h01C, NOP, 32'h018, 0, 32'h01C};
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_reset();
        rst_n = 1;
        for (int i = 0; i < 9; i++) begin
            flush = tv[i].fl; bubble = tv[i].bb; imem_vld = tv[i].vl; tgt = tv[i].tg;
            step();
            chk($sformatf("tv%0d_req", i), 32'(imem_req), 1);
            chk($sformatf("tv%0d_addr", i), imem_addr, tv[i].addr);
            chk($sformatf("tv%0d_inst", i), if_inst, tv[i].inst);
            chk($sformatf("tv%0d_pc", i), if_pc, tv[i].pc);
            chk($sformatf("tv%0d_taken", i), 32'(if_taken), 32'(tv[i].tk));
            chk($sformatf("tv%0d_nt", i), if_nt_pc, tv[i].nt);
        end
        // forward branch not taken
        mem[8] = enc_b(8);
        step();
        chk("fwd_addr0", imem_addr, 32'h20);
        step();
        chk("fwd_addr", imem_addr, 32'h24);
        chk("fwd_inst", if_inst, enc_b(8));
        chk("fwd_taken", 32'(if_taken), 0);
        // interlock holds everything
        bubble = 1;
        repeat (2) begin
            step();
            chk("stall_addr", imem_addr, 32'h24);
            chk("stall_inst", if_inst, enc_b(8));
            chk("stall_pc", if_pc, 32'h20);
            chk("stall_taken", 32'(if_taken), 0);
            chk("stall_nt", if_nt_pc, 32'h24);
            chk("stall_jalr", if_jalr_pci, 32'h20);
        end
        bubble = 0;
        step();
        chk("resume_addr", imem_addr, 32'h28);
        chk("resume_pc", if_pc, 32'h24);
        // flush beats stall
        mem[128] = 32'h0050_0093;
        flush = 1; bubble = 1; tgt = 32'h200;
        step();
        chk("flush_addr", imem_addr, 32'h200);
        chk("flush_inst", if_inst, NOP);
        chk("flush_taken", 32'(if_taken), 0);
        flush = 0; bubble = 0;
        step();
        chk("redir_inst", if_inst, 32'h0050_0093);
        chk("redir_pc", if_pc, 32'h200);
        chk("redir_addr", imem_addr, 32'h204);
        // wait states
        mem[16] = 32'h0070_0113;
        flush = 1; tgt = 32'h40;
        step();
        flush = 0; imem_vld = 0;
        repeat (3) begin
            step();
            chk("wait_inst", if_inst, NOP);
            chk("wait_addr", imem_addr, 32'h40);
            chk("wait_taken", 32'(if_taken), 0);
        end
        imem_vld = 1;
        step();
        chk("wait_done_inst", if_inst, 32'h0070_0113);
        chk("wait_done_pc", if_pc, 32'h40);
        chk("wait_done_addr", imem_addr, 32'h44);
        // JALR partial PC
        mem[12] = enc_jalr(32'h7FC);
        flush = 1; tgt = 32'h30;
        step();
        flush = 0;
        step();
        chk("jalr_inst", if_inst, enc_jalr(32'h7FC));
        chk("jalr_pc", if_pc, 32'h30);
        chk("jalr_taken", 32'(if_taken), 0);
        chk("jalr_pci", if_jalr_pci, 32'h82C);
        chk("jalr_nt", if_nt_pc, 32'h34);
        chk("jalr_addr", imem_addr, 32'h34);
        // async reset mid-operation
        #2 rst_n = 0;
        #1;
        chk_reset();
        m_reset();
        @(posedge clk);
        #1;
        rst_n = 1;
        // randomized run against the model
        foreach (mem[i]) begin
            case ($urandom_range(0, 4))
                0: mem[i] = NOP;
                1: mem[i] = enc_j(int'($urandom_range(0, 1023)) * 2 - 1024);
                2: mem[i] = enc_b(int'($urandom_range(0, 511)) * 2 - 512);
                3: mem[i] = enc_jalr(int'($urandom_range(0, 4095)));
                default: mem[i] = $urandom;
            endcase
        end
        for (int c = 0; c < 3000; c++) begin
            flush = $urandom_range(0, 15) == 0;
            bubble = $urandom_range(0, 4) == 0;
            imem_vld = $urandom_range(0, 4) != 0;
            tgt = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 1023));
            step();
            chk("rnd_req", 32'(imem_req), 32'(m_run));
            chk("rnd_addr", imem_addr, m_pc);
            chk("rnd_inst", if_inst, m_inst);
            chk("rnd_taken", 32'(if_taken), 32'(m_taken));
            if (m_valid) begin
                chk("rnd_pc", if_pc, m_pcq);
                chk("rnd_nt", if_nt_pc, m_nt);
                chk("rnd_jalr", if_jalr_pci, m_jalr);
            end
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
